// File: rtl/seq_serial_tx.sv
// seq_serial_tx: MSB-first serial word transmitter with repeat count, abort and done pulse
module seq_serial_tx #(
  parameter int   WIDTH      = 8,
  parameter int   RPT_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [RPT_W-1:0] load_rpt,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sr, w_sr, r_hold, w_hold;
  logic [BW-1:0]    r_bcnt, w_bcnt;
  logic [RPT_W-1:0] r_rcnt, w_rcnt;
  logic             r_x, w_x, r_xv, w_xv, r_busy, w_busy, r_done, w_done, r_ready, w_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_hold  <= '0;
      r_bcnt  <= '0;
      r_rcnt  <= '0;
      r_x     <= IDLE_LEVEL;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state;
      r_sr    <= w_sr;
      r_hold  <= w_hold;
      r_bcnt  <= w_bcnt;
      r_rcnt  <= w_rcnt;
      r_x     <= w_x;
      r_xv    <= w_xv;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_ready <= w_ready;
    end
  end
  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_hold  = r_hold;
    w_bcnt  = r_bcnt;
    w_rcnt  = r_rcnt;
    w_x     = IDLE_LEVEL;
    w_xv    = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_ready = 1'b1;
    if (r_state == IDLE) begin
      if (load_valid) begin
        w_state = SHIFT;
        w_sr    = load_data;
        w_hold  = load_data;
        w_rcnt  = load_rpt;
        w_bcnt  = BW'(WIDTH - 1);
        w_x     = load_data[WIDTH-1];
        w_xv    = 1'b1;
        w_busy  = 1'b1;
        w_ready = 1'b0;
      end
    end else if (abort) begin
      w_state = IDLE;
      w_sr    = '0;
      w_hold  = '0;
      w_bcnt  = '0;
      w_rcnt  = '0;
    end else if (r_bcnt != '0) begin
      w_sr    = r_sr << 1;
      w_bcnt  = r_bcnt - 1'b1;
      w_x     = r_sr[WIDTH-2];
      w_xv    = 1'b1;
      w_busy  = 1'b1;
      w_ready = 1'b0;
    end else if (r_rcnt != '0) begin
      w_sr    = r_hold;
      w_rcnt  = r_rcnt - 1'b1;
      w_bcnt  = BW'(WIDTH - 1);
      w_x     = r_hold[WIDTH-1];
      w_xv    = 1'b1;
      w_busy  = 1'b1;
      w_ready = 1'b0;
    end else begin
      w_state = IDLE;
      w_done  = 1'b1;
    end
  end
  assign load_ready = r_ready;
  assign x          = r_x;
  assign x_valid    = r_xv;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_seq_serial_tx.sv
// tb_seq_serial_tx: directed and randomized checks of seq_serial_tx against a bit-queue model
module tb_seq_serial_tx;
  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, abort = 1'b0;
  logic [W-1:0] load_data = '0;
  logic [3:0]   load_rpt = '0;
  logic load_ready, x, x_valid, busy, done;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit mq[$];
  bit m_done = 1'b0;
  seq_serial_tx #(.WIDTH(W), .RPT_W(4), .IDLE_LEVEL(IDLE)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_rpt(load_rpt), .abort(abort),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic model_edge();
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      m_done = 1'b0;
      if (abort) mq.delete();
      else begin
        void'(mq.pop_front());
        m_done = (mq.size() == 0);
      end
    end else begin
      m_done = 1'b0;
      if (load_valid)
        for (int r = 0; r <= int'(load_rpt); r++)
          for (int b = W - 1; b >= 0; b--) mq.push_back(load_data[b]);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("x", x, mq.size() != 0 ? mq[0] : IDLE);
      chk("x_valid", x_valid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      chk("load_ready", load_ready, mq.size() == 0);
      chk("done", done, m_done);
    end
  end
  task automatic send(input logic [W-1:0] d, input logic [3:0] r, input int inj_c,
                      input logic [W-1:0] inj_d, output logic [63:0] bits, output int n,
                      output int done_at);
    load_valid = 1'b1;
    load_data  = d;
    load_rpt   = r;
    cyc();
    load_valid = 1'b0;
    bits = '0;
    n = 0;
    done_at = -1;
    for (int c = 1; c < 200 && done_at < 0; c++) begin
      if (x_valid) begin
        bits = {bits[62:0], x};
        n++;
      end
      if (done) done_at = c;
      load_valid = (c == inj_c);
      if (c == inj_c) load_data = inj_d;
      cyc();
    end
    load_valid = 1'b0;
  endtask
  initial begin
    logic [63:0] bits;
    int n, dat, dones;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", load_ready, 1);
    chk("rst_xvalid", x_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, IDLE);
    send(8'hA5, 4'd0, -1, '0, bits, n, dat);
    chk("a5_bits", bits, 64'hA5);
    chk("a5_len", n, 8);
    chk("a5_done_cycle", dat, 9);
    send(8'hC3, 4'd2, -1, '0, bits, n, dat);
    chk("c3_bits", bits, 64'hC3C3C3);
    chk("c3_len", n, 24);
    chk("c3_done_cycle", dat, 25);
    send(8'hFF, 4'd15, -1, '0, bits, n, dat);
    chk("maxrpt_len", n, 128);
    chk("maxrpt_done_cycle", dat, 129);
    cyc();
    load_valid = 1'b1;
    load_data  = 8'hF0;
    load_rpt   = 4'd0;
    cyc();
    for (int c = 1; c < 9; c++) cyc();
    chk("b2b_done", done, 1);
    chk("b2b_gap_xvalid", x_valid, 0);
    chk("b2b_gap_ready", load_ready, 1);
    load_data = 8'h0F;
    cyc();
    load_valid = 1'b0;
    chk("b2b_second_xvalid", x_valid, 1);
    chk("b2b_second_msb", x, 0);
    bits = '0;
    for (int c = 0; c < 8; c++) begin
      bits = {bits[62:0], x};
      cyc();
    end
    chk("b2b_second_bits", bits, 64'h0F);
    chk("b2b_second_done", done, 1);
    cyc();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    load_rpt   = 4'd3;
    cyc();
    load_valid = 1'b0;
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_xvalid", x_valid, 0);
    chk("abort_x", x, IDLE);
    chk("abort_ready", load_ready, 1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      dones += int'(done);
      cyc();
    end
    chk("abort_no_done", dones, 0);
    load_valid = 1'b1;
    load_data  = 8'hAA;
    load_rpt   = 4'd0;
    cyc();
    load_valid = 1'b0;
    for (int c = 1; c < 5; c++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_xvalid", x_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", load_ready, 1);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      dones += int'(done);
      cyc();
    end
    chk("midrst_no_done", dones, 0);
    send(8'h81, 4'd0, -1, '0, bits, n, dat);
    chk("after_rst_bits", bits, 64'h81);
    chk("after_rst_done_cycle", dat, 9);
    send(8'h33, 4'd0, 3, 8'h55, bits, n, dat);
    chk("busy_load_bits", bits, 64'h33);
    chk("busy_load_len", n, 8);
    chk("busy_load_done_cycle", dat, 9);
    abort = 1'b1;
    load_valid = 1'b1;
    load_data = 8'h96;
    cyc();
    abort = 1'b0;
    load_valid = 1'b0;
    chk("abort_idle_load_xvalid", x_valid, 1);
    chk("abort_idle_load_msb", x, 1);
    for (int c = 0; c < 20; c++) cyc();
    for (int i = 0; i < 3000; i++) begin
      rst        = $urandom_range(0, 99) < 2;
      load_valid = $urandom_range(0, 99) < 30;
      load_data  = W'($urandom);
      load_rpt   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      abort      = $urandom_range(0, 99) < 4;
      cyc();
    end
    rst = 1'b0;
    load_valid = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 150; c++) cyc();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
